// File: rtl/wb_stream_writer.sv
// Wishbone write master: drains one valid/ready stream word per classic single-beat write, CYC held per command.
// One word in flight; s_ready is only raised in FETCH, so the stream is stalled while a beat awaits ack/err.
module wb_stream_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_STEP - ADDR_WIDTH'(1));

  // ZERO_LEN is a one-cycle stop so an empty command still shows busy then done.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WRITE    = 2'd2,
    ZERO_LEN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    s_ready_q, s_ready_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    we_q, we_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    stb_q, stb_d;
  logic                    cyc_q, cyc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      s_ready_q   <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    s_ready_d   = s_ready_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    stb_d       = stb_q;
    cyc_d       = cyc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr & ADDR_MASK;
          cnt_d       = cmd_len;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_len == '0) begin
            state_d = ZERO_LEN;
          end else begin
            state_d   = FETCH;
            cyc_d     = 1'b1;
            s_ready_d = 1'b1;
          end
        end
      end

      ZERO_LEN: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end

      FETCH: begin
        if (s_valid && s_ready_q) begin
          dat_d     = s_data;
          adr_d     = addr_q;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          sel_d     = '1;
          s_ready_d = 1'b0;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        // err wins over a simultaneous ack; the command is abandoned.
        if (wbm_err_i) begin
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          cyc_d       = 1'b0;
          error_d     = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (wbm_ack_i) begin
          stb_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = '0;
          addr_d = addr_q + ADDR_STEP;
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            cyc_d       = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            s_ready_d = 1'b1;
            state_d   = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign s_ready   = s_ready_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = cyc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer with a registered-ack RAM slave that can inject err on a chosen beat.
module tb_wb_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        busy, done, error;

  wb_stream_writer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Slave: ack (or err on beat err_beat) registered one cycle after a new strobe.
  logic [31:0] mem [0:16383];
  logic        s_ack = 1'b0, s_err = 1'b0;
  int          beat = 0;
  int          err_beat = 0;
  int          wr_cnt = 0;
  int          cyc_n = 0;
  logic [15:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [3:0]  log_sel [0:63];
  int          log_cyc [0:63];

  assign wbm_ack_i = s_ack;
  assign wbm_err_i = s_err;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      beat  <= 0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (!wbm_cyc_o) begin
        beat <= 0;
      end else if (wbm_stb_o && !s_ack && !s_err) begin
        beat <= beat + 1;
        if (beat + 1 == err_beat) begin
          s_err <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          if (wbm_we_o) mem[wbm_adr_o[15:2]] <= wbm_dat_o;
          if (wr_cnt < 64) begin
            log_adr[wr_cnt] <= wbm_adr_o;
            log_dat[wr_cnt] <= wbm_dat_o;
            log_sel[wr_cnt] <= wbm_sel_o;
            log_cyc[wr_cnt] <= cyc_n;
          end
          wr_cnt <= wr_cnt + 1;
        end
      end
    end
  end

  // Level counters sampled on the falling edge; read them as before/after differences.
  int n_done = 0, n_busy = 0, n_cyc = 0, n_srdy = 0;
  always @(negedge clk) begin
    if (done)      n_done <= n_done + 1;
    if (busy)      n_busy <= n_busy + 1;
    if (wbm_cyc_o) n_cyc  <= n_cyc + 1;
    if (s_ready)   n_srdy <= n_srdy + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] l);
    int t;
    t = 0;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept_wait", 64'(t < 20), 64'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input int bound, output bit ok);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < bound) begin
      @(negedge clk);
      t++;
    end
    ok = s_ready;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int t;
    t = 0;
    while (!done && t < bound) begin
      @(negedge clk);
      t++;
    end
    ok = done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int b, d0, bz0, cz0, sz0;
    logic [31:0] basic_w [0:3];
    basic_w[0] = 32'h11111111;
    basic_w[1] = 32'h22222222;
    basic_w[2] = 32'h33333333;
    basic_w[3] = 32'h44444444;

    // Reset values
    @(negedge clk);
    chk("rst_outputs", 64'({cmd_ready, s_ready, wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o,
                             wbm_adr_o, wbm_dat_o, busy, done, error}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("idle_s_ready", 64'(s_ready), 64'(0));

    // Basic 4-word write
    b  = wr_cnt;
    d0 = n_done;
    send_cmd(16'h0100, 16'd4);
    chk("basic_busy_cyc", 64'({busy, wbm_cyc_o, cmd_ready}), 64'(3'b110));
    for (int i = 0; i < 4; i++) begin
      push_word(basic_w[i], 20, ok);
      chk("basic_push", 64'(ok), 64'(1));
    end
    wait_done(20, ok);
    chk("basic_done", 64'(ok), 64'(1));
    chk("basic_end_state", 64'({wbm_cyc_o, busy, cmd_ready}), 64'(3'b001));
    @(negedge clk);
    @(negedge clk);
    chk("basic_done_count", 64'(n_done - d0), 64'(1));
    chk("basic_writes", 64'(wr_cnt - b), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("basic_adr", 64'(log_adr[b+i]), 64'(16'h0100 + 16'(4*i)));
      chk("basic_sel", 64'(log_sel[b+i]), 64'(4'hF));
      chk("basic_ram", 64'(mem[(16'h0100 >> 2) + i]), 64'(basic_w[i]));
    end
    chk("basic_rate", 64'(log_cyc[b+1] - log_cyc[b]), 64'(3));

    // Misaligned start with address wrap
    b = wr_cnt;
    send_cmd(16'hFFFB, 16'd4);
    for (int i = 0; i < 4; i++) begin
      push_word(32'hA0000000 + 32'(i), 20, ok);
    end
    wait_done(20, ok);
    chk("wrap_done", 64'(ok), 64'(1));
    chk("wrap_adr0", 64'(log_adr[b]),   64'(16'hFFF8));
    chk("wrap_adr1", 64'(log_adr[b+1]), 64'(16'hFFFC));
    chk("wrap_adr2", 64'(log_adr[b+2]), 64'(16'h0000));
    chk("wrap_adr3", 64'(log_adr[b+3]), 64'(16'h0004));
    chk("wrap_ram2", 64'(mem[0]), 64'(32'hA0000002));
    @(negedge clk);

    // Zero length
    bz0 = n_busy; cz0 = n_cyc; sz0 = n_srdy; d0 = n_done;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    send_cmd(16'h0200, 16'd0);
    chk("zero_first", 64'({busy, done, wbm_cyc_o, s_ready}), 64'(4'b1000));
    @(negedge clk);
    chk("zero_done", 64'({busy, done, cmd_ready}), 64'(3'b011));
    @(negedge clk);
    chk("zero_after", 64'({busy, done}), 64'(0));
    @(negedge clk);
    s_valid = 1'b0;
    chk("zero_busy_cycles", 64'(n_busy - bz0), 64'(1));
    chk("zero_done_count", 64'(n_done - d0), 64'(1));
    chk("zero_no_bus", 64'((n_cyc - cz0) + (n_srdy - sz0)), 64'(0));

    // Stream stall of 5 cycles after word 1, with an ignored command pulse
    b = wr_cnt;
    send_cmd(16'h0600, 16'd3);
    push_word(32'h60000001, 20, ok);
    begin
      int cyc_hi, stb_lo;
      cyc_hi = 0; stb_lo = 0;
      for (int i = 0; i < 5; i++) begin
        if (wbm_cyc_o) cyc_hi++;
        if (!wbm_stb_o) stb_lo++;
        if (i == 2) begin
          cmd_addr  = 16'h4000;
          cmd_len   = 16'd1;
          cmd_valid = 1'b1;
          chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        if (i == 3) cmd_valid = 1'b0;
        if (i == 4) chk("stall_fetch", 64'({wbm_cyc_o, wbm_stb_o, s_ready}), 64'(3'b101));
        @(negedge clk);
      end
      chk("stall_cyc_held", 64'(cyc_hi), 64'(5));
      chk("stall_stb_low", 64'(stb_lo), 64'(3));
    end
    push_word(32'h60000002, 20, ok);
    push_word(32'h60000003, 20, ok);
    wait_done(20, ok);
    chk("stall_done", 64'(ok), 64'(1));
    repeat (4) @(negedge clk);
    chk("stall_writes", 64'(wr_cnt - b), 64'(3));
    chk("stall_idle", 64'(busy), 64'(0));
    chk("stall_ram2", 64'(mem[(16'h0600 >> 2) + 2]), 64'(32'h60000003));

    // Bus error on beat 2
    b = wr_cnt;
    err_beat = 2;
    send_cmd(16'h0800, 16'd4);
    push_word(32'h80000001, 20, ok);
    push_word(32'h80000002, 20, ok);
    @(negedge clk);
    chk("err_pending", 64'({wbm_cyc_o, wbm_stb_o, wbm_err_i}), 64'(3'b111));
    @(negedge clk);
    chk("err_abort", 64'({wbm_cyc_o, wbm_stb_o, error, done, busy}), 64'(5'b00110));
    push_word(32'h80000003, 10, ok);
    chk("err_no_consume", 64'(ok), 64'(0));
    chk("err_sticky", 64'(error), 64'(1));
    chk("err_writes", 64'(wr_cnt - b), 64'(1));
    err_beat = 0;
    send_cmd(16'h0300, 16'd1);
    chk("err_cleared", 64'(error), 64'(0));
    push_word(32'hCAFEF00D, 20, ok);
    wait_done(20, ok);
    chk("err_recover_done", 64'({ok, error}), 64'(2'b10));
    chk("err_recover_ram", 64'(mem[16'h0300 >> 2]), 64'(32'hCAFEF00D));
    @(negedge clk);

    // Asynchronous reset while strobing
    send_cmd(16'h0400, 16'd4);
    push_word(32'h40000001, 20, ok);
    chk("arst_pre_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'(2'b11));
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_immediate", 64'({wbm_cyc_o, wbm_stb_o, done, busy}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("arst_no_done", 64'(n_done - d0), 64'(0));
    b = wr_cnt;
    send_cmd(16'h0500, 16'd2);
    push_word(32'h50000001, 20, ok);
    push_word(32'h50000002, 20, ok);
    wait_done(20, ok);
    chk("arst_rerun_done", 64'(ok), 64'(1));
    chk("arst_rerun_adr", 64'({log_adr[b], log_adr[b+1]}), 64'({16'h0500, 16'h0504}));
    chk("arst_rerun_ram", 64'(mem[(16'h0500 >> 2) + 1]), 64'(32'h50000002));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
- Wishbone master that sits directly upstream of wb_ram.
- Accepts a write command (start byte address, word count) plus a valid/ready data stream, and writes each stream word into consecutive words of the slave.
- Used for bulk preload of on-chip RAM from a stream source.
- One word in flight at a time; single-beat classic Wishbone cycles, with CYC held across the whole command.

Parameters:
DATA_WIDTH, 32, Wishbone and stream data width.
ADDR_WIDTH, 16, Wishbone byte address width.
SELECT_WIDTH, DATA_WIDTH/8, byte-select width; also the byte address increment per word.
LEN_WIDTH, 16, width of the word-count field.

Ports:
clk  in  1  clock; all logic rises on posedge.
rst_n  in  1  asynchronous active-low reset.
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(SELECT_WIDTH) bits ignored (forced 0).
cmd_len  in  LEN_WIDTH  number of words to write.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
s_data  in  DATA_WIDTH  stream data word.
s_valid  in  1  stream word valid.
s_ready  out  1  stream word consumed when s_valid&&s_ready.
wbm_adr_o  out  ADDR_WIDTH  Wishbone address.
wbm_dat_o  out  DATA_WIDTH  Wishbone write data.
wbm_we_o  out  1  write enable.
wbm_sel_o  out  SELECT_WIDTH  byte selects.
wbm_stb_o  out  1  strobe.
wbm_cyc_o  out  1  cycle.
wbm_ack_i  in  1  slave acknowledge.
wbm_err_i  in  1  slave error.
busy  out  1  high from command accept until return to IDLE.
done  out  1  one-cycle pulse at end of each command.
error  out  1  sticky: last command aborted by wbm_err_i.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready, s_ready, stb, cyc, we, sel, adr, dat, busy, done, error.
  - Reset mid-transfer aborts immediately: cyc/stb drop asynchronously, no done pulse.
- All outputs are registered.
- IDLE:
  - cmd_ready=1 (first cycle after reset release onward).
  - On accept: addr_reg = cmd_addr with low bits cleared; cnt = cmd_len; error cleared; busy=1; cmd_ready=0.
  - If cmd_len==0: done pulses next cycle, busy returns to 0, no bus activity, stay IDLE.
  - Else go to FETCH, asserting cyc=1.
- FETCH:
  - s_ready=1; stb=0; cyc=1 held.
  - On s_valid&&s_ready: wbm_dat_o=s_data; adr=addr_reg; stb=1; we=1; sel=all ones; s_ready=0. Go to WRITE.
  - While s_valid is low: wait indefinitely, cyc held, no strobe.
- WRITE:
  - stb/we/sel/adr/dat held stable until ack or err.
  - On ack: stb=0, we=0, sel=0; addr_reg += SELECT_WIDTH, wrapping modulo 2^ADDR_WIDTH; cnt -= 1.
    - If cnt was 1: cyc=0, done=1 for one cycle, busy=0, go to IDLE (cmd_ready=1 the same cycle done is high).
    - Else go to FETCH.
  - On err (ack ignored if both high): stb=0, cyc=0, error=1, done=1, busy=0, go to IDLE. Remaining stream words are not consumed.
- Throughput:
  - With a wb_ram slave (ack one cycle after stb) and continuous s_valid: one word per 3 cycles (stb, ack, fetch).
  - With a zero-wait-state slave: one word per 2 cycles.
- cnt is LEN_WIDTH bits; maximum command is 2^LEN_WIDTH-1 words.
- Address wrap is silent; there is no boundary check.
- cmd_valid while busy is ignored (cmd_ready=0).
- Stream words offered in IDLE are not consumed (s_ready=0).
- Error remains asserted until the next command is accepted.

Test Plan:
- Basic write: cmd_addr=0x0100, cmd_len=4, stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 continuous, wb_ram attached.
  - Writes to 0x0100, 0x0104, 0x0108, 0x010C with sel=0xF.
  - Exactly one done pulse; busy low afterwards; RAM readback matches.
- Alignment and wrap: cmd_addr=0xFFFB, cmd_len=4.
  - Writes to 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Zero length: cmd_len=0.
  - done pulses the cycle after accept.
  - cyc/stb never assert; s_ready stays 0; busy high for exactly one cycle.
- Stream stall: cmd_len=3, s_valid low for 5 cycles between words 1 and 2.
  - cyc stays 1, stb stays 0 during the stall, exactly 3 acked writes.
  - Wrong-state stimulus: cmd_valid pulsed mid-transfer is ignored.
- Bus error: drive wbm_err_i on the 2nd beat of a 4-word command.
  - Next cycle: cyc=0, error=1, done pulse; words 3-4 not consumed.
  - A following cmd_len=1 clears error and completes normally.
- Async reset: assert rst_n low while stb=1 in a 4-word command.
  - cyc/stb/done/busy go to 0 without a clock edge.
  - After release, cmd_ready=1 and a new command runs correctly.
